traffic_sensor_cond: RTL and testbench

Vehicle-detector conditioning stage that directly feeds the two-street traffic light controller's `Ta`/`Tb` traffic inputs. It synchronises and debounces the raw loop-detector signals for street A and street B, stretches each detection by a hold time, and arbitrates contested demand so that neither street's demand input can hold its green indefinitely. The outputs are clean, registered, glitch-free and connect straight to the controller's `Ta`/`Tb` ports.

---
 rtl/traffic_sensor_cond.sv | 200 ++++++++++++++++++++
 tb/tb_traffic_sensor_cond.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_sensor_cond.sv
// rtl/traffic_sensor_cond.sv - loop-detector conditioning and demand arbitration for Ta/Tb
//
// traffic_sensor_lane: one detector channel. It synchronises, debounces and
// hold-stretches the detector, and it produces the lane's demand and arrival pulse.
//   clk, reset : clock, asynchronous active-high reset
//   raw        : asynchronous, bouncy loop-detector input
//   dem        : demand = debounced level or hold still running (combinational)
//   arrive     : one-cycle pulse on the edge after the debounced level rises
//
// traffic_sensor_cond: two lanes plus per-lane IDLE/ACTIVE/CUTOFF arbitration.
//   clk, reset       : clock, asynchronous active-high reset
//   raw_a, raw_b     : street A / B loop detectors
//   Ta, Tb           : traffic present, decoded from the lane state registers
//   a_arrive/b_arrive: debounced arrival pulses
//   a_cut, b_cut     : lane currently held in CUTOFF

`timescale 1ns/1ps

module traffic_sensor_lane #(
    parameter int DEB_CYCLES  = 4,
    parameter int HOLD_CYCLES = 8,
    parameter int CNT_W       = 6
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic dem,
    output logic arrive
);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    logic             sync1;
    logic             sync2;
    logic             stable;
    logic             stable_d;
    logic [CNT_W-1:0] deb_cnt;
    logic [CNT_W-1:0] hold_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            stable   <= 1'b0;
            stable_d <= 1'b0;
            deb_cnt  <= '0;
            hold_cnt <= '0;
            arrive   <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;

            // deb_cnt counts consecutive disagreeing samples; the last one flips stable.
            if (sync2 == stable) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                stable  <= ~stable;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + ONE;
            end

            stable_d <= stable;
            arrive   <= stable & ~stable_d;

            // Reloaded every cycle the detector is present. It then runs down after the fall.
            if (stable) begin
                hold_cnt <= HOLD_LOAD;
            end else if (hold_cnt != '0) begin
                hold_cnt <= hold_cnt - ONE;
            end
        end
    end

    assign dem = stable | (hold_cnt != '0);
endmodule

module traffic_sensor_cond #(
    parameter int DEB_CYCLES  = 4,
    parameter int HOLD_CYCLES = 8,
    parameter int MAX_GREEN   = 32,
    parameter int CNT_W       = 6
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_a,
    input  logic raw_b,
    output logic Ta,
    output logic Tb,
    output logic a_arrive,
    output logic b_arrive,
    output logic a_cut,
    output logic b_cut
);
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACTIVE = 2'b01,
        CUTOFF = 2'b10
    } lane_state_t;

    localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    lane_state_t      state_a;
    lane_state_t      state_b;
    lane_state_t      state_a_nxt;
    lane_state_t      state_b_nxt;
    logic [CNT_W-1:0] run_a;
    logic [CNT_W-1:0] run_b;
    logic             dem_a;
    logic             dem_b;
    logic             cut_a;
    logic             cut_b;

    traffic_sensor_lane #(
        .DEB_CYCLES (DEB_CYCLES),
        .HOLD_CYCLES(HOLD_CYCLES),
        .CNT_W      (CNT_W)
    ) u_lane_a (
        .clk   (clk),
        .reset (reset),
        .raw   (raw_a),
        .dem   (dem_a),
        .arrive(a_arrive)
    );

    traffic_sensor_lane #(
        .DEB_CYCLES (DEB_CYCLES),
        .HOLD_CYCLES(HOLD_CYCLES),
        .CNT_W      (CNT_W)
    ) u_lane_b (
        .clk   (clk),
        .reset (reset),
        .raw   (raw_b),
        .dem   (dem_b),
        .arrive(b_arrive)
    );

    always_comb begin
        // B wins a simultaneous cutoff. A may not cut off while B is parked in CUTOFF.
        cut_b = (state_b == ACTIVE) && dem_b && (run_b == RUN_LAST) && dem_a;
        cut_a = (state_a == ACTIVE) && dem_a && (run_a == RUN_LAST) && dem_b &&
                !cut_b && (state_b != CUTOFF);

        state_a_nxt = state_a;
        state_b_nxt = state_b;

        case (state_a)
            IDLE:    if (dem_a) state_a_nxt = ACTIVE;
            ACTIVE:  if (!dem_a) state_a_nxt = IDLE;
                     else if (cut_a) state_a_nxt = CUTOFF;
            CUTOFF:  if (!dem_a) state_a_nxt = IDLE;
                     else if (cut_b || !dem_b) state_a_nxt = ACTIVE;
            default: state_a_nxt = IDLE;
        endcase

        case (state_b)
            IDLE:    if (dem_b) state_b_nxt = ACTIVE;
            ACTIVE:  if (!dem_b) state_b_nxt = IDLE;
                     else if (cut_b) state_b_nxt = CUTOFF;
            CUTOFF:  if (!dem_b) state_b_nxt = IDLE;
                     else if (cut_a || !dem_a) state_b_nxt = ACTIVE;
            default: state_b_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_a <= IDLE;
            state_b <= IDLE;
            run_a   <= '0;
            run_b   <= '0;
        end else begin
            state_a <= state_a_nxt;
            state_b <= state_b_nxt;

            // run counts cycles spent ACTIVE: cleared on entry, saturating while staying.
            if (state_a_nxt == ACTIVE) begin
                if (state_a != ACTIVE) begin
                    run_a <= '0;
                end else if (run_a != RUN_LAST) begin
                    run_a <= run_a + ONE;
                end
            end
            if (state_b_nxt == ACTIVE) begin
                if (state_b != ACTIVE) begin
                    run_b <= '0;
                end else if (run_b != RUN_LAST) begin
                    run_b <= run_b + ONE;
                end
            end
        end
    end

    assign Ta    = (state_a == ACTIVE);
    assign Tb    = (state_b == ACTIVE);
    assign a_cut = (state_a == CUTOFF);
    assign b_cut = (state_b == CUTOFF);
endmodule

// File: tb/tb_traffic_sensor_cond.sv
// tb/tb_traffic_sensor_cond.sv - directed and random checks of traffic_sensor_cond against a reference model

`timescale 1ns/1ps

module tb_traffic_sensor_cond;
    localparam int DEB  = 4;
    localparam int HOLD = 8;
    localparam int MAXG = 32;

    logic clk = 1'b0;
    logic reset;
    logic raw_a;
    logic raw_b;
    logic Ta, Tb, a_arrive, b_arrive, a_cut, b_cut;

    int checks   = 0;
    int failures = 0;

    traffic_sensor_cond #(
        .DEB_CYCLES (DEB),
        .HOLD_CYCLES(HOLD),
        .MAX_GREEN  (MAXG),
        .CNT_W      (6)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .raw_a   (raw_a),
        .raw_b   (raw_b),
        .Ta      (Ta),
        .Tb      (Tb),
        .a_arrive(a_arrive),
        .b_arrive(b_arrive),
        .a_cut   (a_cut),
        .b_cut   (b_cut)
    );

    always #5 clk = ~clk;

    // Reference model, lane 0 = A, lane 1 = B.
    bit m_s1 [2];
    bit m_s2 [2];
    bit m_stable [2];
    bit m_stable_prev [2];
    bit m_hist [2][DEB];
    int m_quiet [2];
    int m_run [2];
    bit m_green [2];
    bit m_cut [2];
    bit m_arrive [2];

    function automatic void model_reset();
        for (int l = 0; l < 2; l++) begin
            m_s1[l] = 0; m_s2[l] = 0; m_stable[l] = 0; m_stable_prev[l] = 0;
            for (int k = 0; k < DEB; k++) m_hist[l][k] = 0;
            m_quiet[l] = HOLD; m_run[l] = 0;
            m_green[l] = 0; m_cut[l] = 0; m_arrive[l] = 0;
        end
    endfunction

    function automatic void model_edge(input bit ra, input bit rb);
        bit raw [2];
        bit dem [2];
        bit elig [2];
        bit enter [2];
        bit all_diff;
        int o;
        raw[0] = ra; raw[1] = rb;
        for (int l = 0; l < 2; l++) dem[l] = m_stable[l] || (m_quiet[l] < HOLD);
        for (int l = 0; l < 2; l++)
            elig[l] = m_green[l] && dem[l] && dem[1-l] && (m_run[l] >= MAXG - 1);
        enter[1] = elig[1];
        enter[0] = elig[0] && !elig[1] && !m_cut[1];
        for (int l = 0; l < 2; l++) begin
            o = 1 - l;
            if (!m_green[l] && !m_cut[l]) begin
                if (dem[l]) begin m_green[l] = 1; m_run[l] = 0; end
            end else if (m_green[l]) begin
                if (!dem[l]) m_green[l] = 0;
                else if (enter[l]) begin m_green[l] = 0; m_cut[l] = 1; end
                else m_run[l] = m_run[l] + 1;
            end else begin
                if (!dem[l]) m_cut[l] = 0;
                else if (enter[o] || !dem[o]) begin m_cut[l] = 0; m_green[l] = 1; m_run[l] = 0; end
            end
        end
        for (int l = 0; l < 2; l++) begin
            m_arrive[l] = m_stable[l] && !m_stable_prev[l];
            m_stable_prev[l] = m_stable[l];
            m_quiet[l] = m_stable[l] ? 0 : ((m_quiet[l] < HOLD) ? m_quiet[l] + 1 : HOLD);
            for (int k = DEB - 1; k > 0; k--) m_hist[l][k] = m_hist[l][k-1];
            m_hist[l][0] = m_s2[l];
            all_diff = 1;
            for (int k = 0; k < DEB; k++) if (m_hist[l][k] == m_stable[l]) all_diff = 0;
            if (all_diff) m_stable[l] = !m_stable[l];
            m_s2[l] = m_s1[l];
            m_s1[l] = raw[l];
        end
    endfunction

    task automatic chk(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_int(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("model_Ta", Ta, m_green[0]);
        chk("model_Tb", Tb, m_green[1]);
        chk("model_a_cut", a_cut, m_cut[0]);
        chk("model_b_cut", b_cut, m_cut[1]);
        chk("model_a_arrive", a_arrive, m_arrive[0]);
        chk("model_b_arrive", b_arrive, m_arrive[1]);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_Ta"}, Ta, 1'b0);
        chk({tag, "_Tb"}, Tb, 1'b0);
        chk({tag, "_a_cut"}, a_cut, 1'b0);
        chk({tag, "_b_cut"}, b_cut, 1'b0);
        chk({tag, "_a_arrive"}, a_arrive, 1'b0);
        chk({tag, "_b_arrive"}, b_arrive, 1'b0);
    endtask

    // Inputs change on the falling edge; the rising edge that follows is one counted edge.
    task automatic step(input logic a, input logic b);
        @(negedge clk);
        raw_a = a;
        raw_b = b;
        reset = 1'b0;
        @(posedge clk);
        model_edge(a, b);
        #1;
        check_model();
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_zero("reset");
    endtask

    initial begin
        bit seen;
        bit any_hi;
        int hi_a, hi_b, fell_at, hit_at;
        bit tgt [2];
        logic ra, rb;

        reset = 1'b1; raw_a = 1'b0; raw_b = 1'b0;
        model_reset();
        @(posedge clk); #1;
        check_zero("por");

        // Reset and idle
        for (int n = 0; n < 20; n++) step(1, 0);
        chk("pre_reset_Ta", Ta, 1'b1);
        pulse_reset();
        any_hi = 0;
        for (int n = 0; n < 50; n++) begin
            step(0, 0);
            if (Ta || Tb || a_cut || b_cut || a_arrive || b_arrive) any_hi = 1;
        end
        chk("idle_quiet", any_hi, 1'b0);

        // Debounce: short pulse rejected, then a step gives arrival and Ta on edge 7
        any_hi = 0;
        for (int n = 0; n < 3; n++) begin step(1, 0); if (Ta || a_arrive) any_hi = 1; end
        for (int n = 0; n < 20; n++) begin step(0, 0); if (Ta || a_arrive) any_hi = 1; end
        chk("short_pulse_ignored", any_hi, 1'b0);
        for (int n = 1; n <= 6; n++) step(1, 0);
        chk("rise_edge6_Ta", Ta, 1'b0);
        chk("rise_edge6_arrive", a_arrive, 1'b0);
        step(1, 0);
        chk("rise_edge7_Ta", Ta, 1'b1);
        chk("rise_edge7_arrive", a_arrive, 1'b1);
        step(1, 0);
        chk("rise_edge8_arrive", a_arrive, 1'b0);

        // Hold: fall latency 15 edges, then re-detection inside the hold leaves no gap
        for (int n = 0; n < 12; n++) step(1, 0);
        for (int n = 1; n <= 15; n++) begin
            step(0, 0);
            if (n == 14) chk("fall_edge14_Ta", Ta, 1'b1);
            if (n == 15) chk("fall_edge15_Ta", Ta, 1'b0);
        end
        for (int n = 0; n < 20; n++) step(1, 0);
        fell_at = 0;
        for (int n = 1; n <= 40; n++) begin
            step((n >= 6 && n <= 10) ? 1'b1 : 1'b0, 0);
            if (!Ta && fell_at == 0) fell_at = n;
        end
        chk_int("redetect_fall_edge", fell_at, 25);

        // Cutoff: A served 32 cycles, then B served 32 cycles and A resumes
        pulse_reset();
        for (int n = 0; n < 7; n++) step(1, 0);
        chk("cut_a_on", Ta, 1'b1);
        hi_a = 1; hi_b = 0; seen = 0;
        for (int n = 0; n < 80 && !seen; n++) begin
            step(1, 1);
            if (Tb) hi_b++;
            if (a_cut) seen = 1;
            else if (Ta) hi_a++;
        end
        chk("a_cut_seen", seen, 1'b1);
        chk_int("a_green_len", hi_a, MAXG);
        chk("a_cut_Ta", Ta, 1'b0);
        chk("a_cut_Tb", Tb, 1'b1);
        seen = 0;
        for (int n = 0; n < 80 && !seen; n++) begin
            step(1, 1);
            if (b_cut) seen = 1;
            else if (Tb) hi_b++;
        end
        chk("b_cut_seen", seen, 1'b1);
        chk_int("b_green_len", hi_b, MAXG);
        chk("b_cut_Ta", Ta, 1'b1);
        chk("b_cut_a_cut", a_cut, 1'b0);
        chk("b_cut_Tb", Tb, 1'b0);

        // Reset mid-cutoff, then simultaneous arrival with both raws held high
        pulse_reset();
        for (int n = 0; n < 7; n++) step(1, 0);
        seen = 0;
        for (int n = 0; n < 80 && !seen; n++) begin
            step(1, 1);
            if (a_cut) seen = 1;
        end
        chk("a_cut_again", seen, 1'b1);
        pulse_reset();
        for (int n = 1; n <= 6; n++) step(1, 1);
        chk("sim_edge6_Ta", Ta, 1'b0);
        chk("sim_edge6_Tb", Tb, 1'b0);
        step(1, 1);
        chk("sim_edge7_Ta", Ta, 1'b1);
        chk("sim_edge7_Tb", Tb, 1'b1);
        hit_at = 0;
        for (int n = 8; n < 90 && hit_at == 0; n++) begin
            step(1, 1);
            if (b_cut) hit_at = n;
        end
        chk_int("sim_b_cut_edge", hit_at, 7 + MAXG);
        chk("sim_Ta_kept", Ta, 1'b1);
        chk("sim_no_a_cut", a_cut, 1'b0);
        chk("sim_Tb_low", Tb, 1'b0);
        for (int n = 0; n < 40; n++) step(1, 1);

        // Random bouncy detectors against the model
        tgt[0] = 0; tgt[1] = 0;
        for (int n = 0; n < 4000; n++) begin
            for (int l = 0; l < 2; l++) if ($urandom_range(59) == 0) tgt[l] = !tgt[l];
            ra = tgt[0] ^ ($urandom_range(5) == 0);
            rb = tgt[1] ^ ($urandom_range(5) == 0);
            if ($urandom_range(1499) == 0) pulse_reset();
            step(ra, rb);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
